// File: rtl/seg7_msg_scroller.sv
// Multi-digit seven-segment message display: buffers a letter-code message
// written over valid/ready and shows it statically or scrolling, with blink and dash override.
module seg7_msg_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_DIV   = 25_000_000,
    parameter int BLINK_DIV  = 12_500_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [3:0]                  wr_letter,
    input  logic                        wr_last,
    input  logic                        scroll_en,
    input  logic                        blink_en,
    output logic [7*NUM_DIGITS-1:0]     seg_out,
    output logic [$clog2(MSG_DEPTH):0]  msg_len,
    output logic                        busy
);

    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int LW = $clog2(MSG_DEPTH) + 1;
    localparam int IW = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW} state_t;

    state_t                  state_reg, state_next;
    logic [LW-1:0]           wr_cnt_reg, wr_cnt_next;
    logic [LW-1:0]           msg_len_reg, msg_len_next;
    logic [IW-1:0]           pos_reg, pos_next;
    logic [TW-1:0]           tick_reg, tick_next;
    logic [BW-1:0]           blink_cnt_reg, blink_cnt_next;
    logic                    phase_reg, phase_next;
    logic [7*NUM_DIGITS-1:0] seg_out_reg, seg_out_next;
    logic [3:0]              buf_mem [2**AW];

    logic                    wr_fire;
    logic                    commit;
    logic [LW-1:0]           wr_idx;
    logic [IW-1:0]           wrap_at;
    logic [7*NUM_DIGITS-1:0] glyph_vec;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:  return 7'b0001000;
            4'd1:  return 7'b0000000;
            4'd2:  return 7'b1000110;
            4'd3:  return 7'b0100001;
            4'd4:  return 7'b0000110;
            4'd5:  return 7'b0001110;
            4'd6:  return 7'b0010000;
            4'd7:  return 7'b0001001;
            4'd8:  return 7'b1111001;
            4'd9:  return 7'b1110001;
            4'd10: return 7'b1000111;
            4'd11: return 7'b1000000;
            4'd12: return 7'b0001100;
            4'd13: return 7'b0101111;
            4'd14: return 7'b1000001;
            default: return 7'b0010001;
        endcase
    endfunction

    assign wr_ready = ~rst;
    assign wr_fire  = wr_valid & wr_ready;
    // Any write outside LOAD begins a fresh message at index 0.
    assign wr_idx   = (state_reg == ST_LOAD) ? wr_cnt_reg : '0;
    assign commit   = wr_fire & (wr_last | (wr_idx == LW'(MSG_DEPTH - 1)));
    assign wrap_at  = IW'(msg_len_reg) + IW'(NUM_DIGITS - 1);

    always_comb begin
        state_next   = state_reg;
        wr_cnt_next  = wr_cnt_reg;
        msg_len_next = msg_len_reg;
        if (wr_fire) begin
            if (commit) begin
                state_next   = ST_SHOW;
                msg_len_next = wr_idx + LW'(1);
                wr_cnt_next  = '0;
            end else begin
                state_next  = ST_LOAD;
                wr_cnt_next = wr_idx + LW'(1);
            end
        end
    end

    always_comb begin
        tick_next = tick_reg;
        pos_next  = pos_reg;
        if (commit) begin
            tick_next = '0;
            pos_next  = '0;
        end else if (state_reg == ST_SHOW && scroll_en) begin
            if (tick_reg == TW'(TICK_DIV - 1)) begin
                tick_next = '0;
                pos_next  = (pos_reg >= wrap_at) ? '0 : pos_reg + IW'(1);
            end else begin
                tick_next = tick_reg + TW'(1);
            end
        end else begin
            tick_next = '0;
            if (state_reg == ST_SHOW)
                pos_next = '0;
        end
    end

    // Blink phase runs freely and is realigned on every commit.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + BW'(1);
        phase_next     = phase_reg;
        if (commit) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [IW-1:0] disp_idx;
            logic [3:0]    letter;
            assign disp_idx = pos_reg + IW'(gi);
            assign letter   = buf_mem[disp_idx[AW-1:0]];
            assign glyph_vec[7*gi +: 7] = (disp_idx < IW'(msg_len_reg)) ? glyph(letter) : BLANK;
        end
    endgenerate

    always_comb begin
        seg_out_next = glyph_vec;
        if (!enable)
            seg_out_next = {NUM_DIGITS{DASH}};
        else if (state_reg != ST_SHOW)
            seg_out_next = {NUM_DIGITS{BLANK}};
        else if (blink_en && phase_reg)
            seg_out_next = {NUM_DIGITS{BLANK}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_cnt_reg    <= '0;
            msg_len_reg   <= '0;
            pos_reg       <= '0;
            tick_reg      <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            seg_out_reg   <= {NUM_DIGITS{BLANK}};
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            msg_len_reg   <= msg_len_next;
            pos_reg       <= pos_next;
            tick_reg      <= tick_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            seg_out_reg   <= seg_out_next;
        end
    end

    // Letter storage needs no reset: nothing beyond msg_len is ever shown.
    always_ff @(posedge clk) begin
        if (wr_fire)
            buf_mem[wr_idx[AW-1:0]] <= wr_letter;
    end

    assign seg_out = seg_out_reg;
    assign msg_len = msg_len_reg;
    assign busy    = (state_reg == ST_SHOW);

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Bench for seg7_msg_scroller: directed vector table, scroll/blink sequences,
// and randomized traffic checked against a message-level reference model.
module tb_seg7_msg_scroller;

    localparam int ND = 4;
    localparam int MD = 8;
    localparam int TD = 4;
    localparam int BD = 3;
    localparam int GB = 16;  // blank digit code in tables
    localparam int GD = 17;  // dash digit code in tables

    logic          clk = 1'b0;
    logic          rst, enable, wr_valid, wr_last, scroll_en, blink_en;
    logic [3:0]    wr_letter;
    logic          wr_ready;
    logic [7*ND-1:0] seg_out;
    logic [3:0]    msg_len;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_msg_scroller #(
        .NUM_DIGITS(ND), .MSG_DEPTH(MD), .TICK_DIV(TD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_letter(wr_letter), .wr_last(wr_last),
        .scroll_en(scroll_en), .blink_en(blink_en),
        .seg_out(seg_out), .msg_len(msg_len), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0:  return 7'b0001000;  1:  return 7'b0000000;
            2:  return 7'b1000110;  3:  return 7'b0100001;
            4:  return 7'b0000110;  5:  return 7'b0001110;
            6:  return 7'b0010000;  7:  return 7'b0001001;
            8:  return 7'b1111001;  9:  return 7'b1110001;
            10: return 7'b1000111;  11: return 7'b1000000;
            12: return 7'b0001100;  13: return 7'b0101111;
            14: return 7'b1000001;  15: return 7'b0010001;
            GB: return 7'b1111111;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [27:0] render(input int d0, input int d1, input int d2, input int d3);
        return {glyph(d3), glyph(d2), glyph(d1), glyph(d0)};
    endfunction

    // Reference model: message-level view; positions derived from elapsed clocks.
    int          m_state;      // 0 idle, 1 loading, 2 showing
    int          m_load[$];
    int          m_msg[MD];
    int          m_len;
    int          scroll_t;     // clocks spent scrolling since commit / scroll restart
    int          blink_t;      // clocks since commit or reset
    logic [27:0] m_seg;

    task automatic model_edge();
        int pos, ph, idx, pre;
        logic do_commit;
        pos = (scroll_t / TD) % (m_len + ND);
        ph  = (blink_t / BD) % 2;
        for (int d = 0; d < ND; d++) begin
            idx = pos + d;
            if (rst)                       m_seg[7*d +: 7] = glyph(GB);
            else if (!enable)              m_seg[7*d +: 7] = glyph(GD);
            else if (m_state != 2)         m_seg[7*d +: 7] = glyph(GB);
            else if (blink_en && ph == 1)  m_seg[7*d +: 7] = glyph(GB);
            else if (idx < m_len)          m_seg[7*d +: 7] = glyph(m_msg[idx]);
            else                           m_seg[7*d +: 7] = glyph(GB);
        end
        if (rst) begin
            m_state = 0; m_load.delete(); m_len = 0; scroll_t = 0; blink_t = 0;
            return;
        end
        pre = m_state;
        do_commit = 1'b0;
        if (wr_valid) begin
            if (m_state != 1) m_load.delete();
            m_load.push_back(int'(wr_letter));
            if (wr_last || m_load.size() == MD) do_commit = 1'b1;
            else m_state = 1;
        end
        if (do_commit) begin
            foreach (m_load[i]) m_msg[i] = m_load[i];
            m_len = m_load.size();
            m_load.delete();
            m_state = 2; scroll_t = 0; blink_t = 0;
        end else begin
            blink_t++;
            if (pre == 2) scroll_t = scroll_en ? scroll_t + 1 : 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [3:0] l,
                         input logic last, input logic sc, input logic bl);
        rst = r; enable = e; wr_valid = v; wr_letter = l; wr_last = last;
        scroll_en = sc; blink_en = bl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg_out), 32'(m_seg));
        check("msg_len", 32'(msg_len), 32'(m_len));
        check("busy", 32'(busy), 32'(m_state == 2));
        check("wr_ready", 32'(wr_ready), 32'(!rst));
    endtask

    typedef struct {
        logic       r, e, v;
        logic [3:0] l;
        logic       last;
        int         d0, d1, d2, d3;
        int         len;
        logic       bz;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input int l, input logic last,
                                input int d0, input int d1, input int d2, input int d3,
                                input int len, input logic bz, input logic e = 1'b1);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.l = 4'(l); t.last = last;
        t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3; t.len = len; t.bz = bz;
        return t;
    endfunction

    int hello[5] = '{7, 4, 10, 10, 11};

    function automatic logic [27:0] hello_view(input int p);
        int dg[4];
        for (int d = 0; d < 4; d++) dg[d] = (p + d < 5) ? hello[p + d] : GB;
        return render(dg[0], dg[1], dg[2], dg[3]);
    endfunction

    vec_t tab[$];

    initial begin
        logic sc, bl;
        logic [27:0] exp;
        int p;

        // HELLO static; single letter from IDLE; auto-commit; reset mid-LOAD; enable override.
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 7, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 4, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 10, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 10, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 11, 1, GB, GB, GB, GB, 5, 1));
        tab.push_back(mk(0, 0, 0, 0, 7, 4, 10, 10, 5, 1));
        tab.push_back(mk(0, 0, 0, 0, 7, 4, 10, 10, 5, 1));
        tab.push_back(mk(0, 0, 0, 0, 7, 4, 10, 10, 5, 1));
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 13, 1, GB, GB, GB, GB, 1, 1));
        tab.push_back(mk(0, 0, 0, 0, 13, GB, GB, GB, 1, 1));
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        for (int i = 0; i < 7; i++) tab.push_back(mk(0, 1, i, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 7, 0, GB, GB, GB, GB, 8, 1));
        tab.push_back(mk(0, 1, 15, 0, 0, 1, 2, 3, 8, 0));
        tab.push_back(mk(0, 0, 0, 0, GB, GB, GB, GB, 8, 0));
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 1, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 2, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 3, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 14, 0, GB, GB, GB, GB, 0, 0));
        tab.push_back(mk(0, 1, 15, 1, GB, GB, GB, GB, 2, 1));
        tab.push_back(mk(0, 0, 0, 0, 14, 15, GB, GB, 2, 1));
        tab.push_back(mk(0, 0, 0, 0, GD, GD, GD, GD, 2, 1, 1'b0));
        tab.push_back(mk(0, 0, 0, 0, 14, 15, GB, GB, 2, 1));

        foreach (tab[i]) begin
            drive(tab[i].r, tab[i].e, tab[i].v, tab[i].l, tab[i].last, 1'b0, 1'b0);
            step();
            check($sformatf("tab%0d_seg", i), 32'(seg_out),
                  32'(render(tab[i].d0, tab[i].d1, tab[i].d2, tab[i].d3)));
            check($sformatf("tab%0d_len", i), 32'(msg_len), 32'(tab[i].len));
            check($sformatf("tab%0d_busy", i), 32'(busy), 32'(tab[i].bz));
            $display("vec %0d: seg=%h msg_len=%0d busy=%0b", i, seg_out, msg_len, busy);
        end

        // Scrolling HELLO through one full wrap and back.
        drive(1, 1, 0, 0, 0, 1, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 4'(hello[i]), i == 4, 1, 0); step();
        end
        drive(0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 44; k++) begin
            step();
            p = ((k - 1) / TD) % (5 + ND);
            check($sformatf("scroll_k%0d", k), 32'(seg_out), 32'(hello_view(p)));
            $display("scroll k=%0d pos=%0d seg=%h", k, p, seg_out);
        end

        // Blink alternation, then enable drop overrides any phase.
        drive(1, 1, 0, 0, 0, 0, 1); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 4'(hello[i]), i == 4, 0, 1); step();
        end
        drive(0, 1, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = (((k - 1) / BD) % 2 == 1) ? render(GB, GB, GB, GB) : hello_view(0);
            check($sformatf("blink_k%0d", k), 32'(seg_out), 32'(exp));
            $display("blink k=%0d seg=%h", k, seg_out);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("dash_k%0d", k), 32'(seg_out), 32'(render(GD, GD, GD, GD)));
            $display("dash k=%0d seg=%h", k, seg_out);
        end

        // Randomized traffic against the reference model.
        drive(1, 1, 0, 0, 0, 0, 0); step();
        sc = 1'b1; bl = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 59) == 0) sc = ~sc;
            if ($urandom_range(0, 79) == 0) bl = ~bl;
            drive($urandom_range(0, 399) == 0,
                  $urandom_range(0, 24) != 0,
                  (m_state == 2) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 1) == 0),
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) == 0,
                  sc, bl);
            step();
            if (c % 200 == 0)
                $display("rand c=%0d seg=%h msg_len=%0d busy=%0b", c, seg_out, msg_len, busy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_msg_scroller.md
# seg7_msg_scroller

Parametrised multi-digit seven-segment message display for the Braille trainer game. It buffers a short message of 4-bit letter codes written over a valid/ready port and renders it across `NUM_DIGITS` active-low digits. The message can be shown statically or scrolled right-to-left, and the display supports blink and blank/dash override. It sits between the game controller, which writes the target word, and the board's seven-segment pins.

## Interface
- `NUM_DIGITS`, 4: number of digits driven; must be ≥1.
- `MSG_DEPTH`, 16: letter buffer depth; power of 2, ≥ `NUM_DIGITS`.
- `TICK_DIV`, 25_000_000: clocks per scroll step; ≥2.
- `BLINK_DIV`, 12_500_000: clocks per blink half-period; ≥2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: 0 forces every digit to dash.
- `wr_valid` in 1: letter write request.
- `wr_ready` out 1: write accepted when `wr_valid & wr_ready`.
- `wr_letter` in 4: letter code.
- `wr_last` in 1: final letter of the message; commits it.
- `scroll_en` in 1: 1 scroll, 0 static.
- `blink_en` in 1: 1 enables blink.
- `seg_out` out 7*`NUM_DIGITS`: active-low segments `{g,f,e,d,c,b,a}`; digit 0 (leftmost) in `[6:0]`.
- `msg_len` out clog2(`MSG_DEPTH`)+1: committed message length.
- `busy` out 1: high in SHOW.

## Operation
Glyph table (code: letter, segments):
- 0 A 0001000, 1 B 0000000, 2 C 1000110, 3 d 0100001
- 4 E 0000110, 5 F 0001110, 6 g 0010000, 7 H 0001001
- 8 I 1111001, 9 J 1110001, 10 L 1000111, 11 O 1000000
- 12 P 0001100, 13 r 0101111, 14 U 1000001, 15 Y 0010001
- Blank is 1111111. Dash is 0111111.

States:
- IDLE: all digits blank. An accepted write stores the letter at index 0 and enters LOAD. If that write also has `wr_last`, it commits directly to SHOW with length 1.
- LOAD: all digits blank. Each accepted write stores at `wr_cnt` and increments `wr_cnt`. Accepting `wr_last`, or accepting the `MSG_DEPTH`-th letter (auto-commit), sets `msg_len = wr_cnt+1` and enters SHOW. Commit also clears `pos` and the tick counter.
- SHOW: digit d displays index i = `pos`+d. If i < `msg_len`, the digit shows `glyph[buf[i]]`; otherwise it is blank.
- SHOW with `scroll_en`=1: `pos` advances every `TICK_DIV` clocks and wraps from `msg_len`+`NUM_DIGITS`-1 to 0, so the message slides fully off before repeating.
- SHOW with `scroll_en`=0: `pos` is forced to 0 and the tick counter is held at 0. Letters beyond `NUM_DIGITS` are not shown.
- A write accepted in SHOW starts a new message: the letter goes to index 0, the state moves to LOAD (or to SHOW if `wr_last`), and `msg_len` is unchanged until the next commit.

Rules:
- `wr_ready` = 1 in every state and deasserts only while `rst` is high.
- Blink: a phase bit toggles every `BLINK_DIV` clocks and runs freely. While `blink_en`=1 and phase=1 in SHOW, all digits are blank. Phase resets to 0 on commit.
- Output priority: `rst` > `enable`=0 (dash) > IDLE/LOAD (blank) > blink (blank) > glyph.
- Index arithmetic uses clog2(`MSG_DEPTH`+`NUM_DIGITS`)+1 bits with no truncation.

## Timing
- Reset values: state IDLE, `seg_out` all blank, `msg_len`=0, `busy`=0, `wr_ready`=0 (while `rst` is high), `pos`=0, all counters and blink phase 0.
- `seg_out` is registered and reflects state/`pos`/inputs one clock after they update. For example, a commit at edge N gives glyphs at edge N+1, and an `enable` change shows at the next edge.
- The first scroll step comes `TICK_DIV` clocks after commit, and subsequent steps every `TICK_DIV` clocks.
- `busy` and `msg_len` update on the commit edge.
- `rst` in any state (mid-LOAD or mid-scroll) returns everything to reset values at the next edge and discards the partial message.

## Test plan
Parameters: `NUM_DIGITS`=4, `MSG_DEPTH`=8, `TICK_DIV`=4, `BLINK_DIV`=3.
1. Reset, then write codes 7,4,10,10,11 ("HELLO") with `wr_last` on the last, `scroll_en`=0 → `msg_len`=5, `busy`=1; `seg_out` digits 0..3 = H,E,L,L one cycle after commit, stable forever.
2. Same message with `scroll_en`=1 → `pos` steps every 4 clocks: HELL, ELLO, LLO_, LO__, O___, ____, ____, ____, ____, then wraps to HELL (`pos` 0..8 → 0).
3. Write 9 letters without `wr_last` → 8th letter auto-commits with `msg_len`=8; 9th letter starts a new message (state LOAD, display blank, `msg_len` still 8).
4. In SHOW with `blink_en`=1 → digits alternate glyph/blank every 3 clocks. Drop `enable` to 0 → all digits 0111111 next cycle, regardless of blink phase.
5. Assert `rst` mid-LOAD after 3 letters, then send a 2-letter message → only the 2 new letters are displayed, `msg_len`=2.
6. Write a single letter 13 with `wr_last` from IDLE → SHOW directly; digit 0 = 0101111, digits 1..3 = 1111111.
